// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic unit (adder and subtractor).
// Holds the FSM state encoding and the default operand width.
package serial_arith_pkg;

  localparam int SER_WIDTH = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the bit-serial subtractor.
// master: drives start, A, B; slave: drives busy, diff_bit, bit_valid, diff, borrow, done, ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             diff_bit;
  logic             bit_valid;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             done;
  logic             ovf;

  modport master (
    output start, A, B,
    input  busy, diff_bit, bit_valid, diff, borrow, done, ovf
  );

  modport slave (
    input  start, A, B,
    output busy, diff_bit, bit_valid, diff, borrow, done, ovf
  );
endinterface

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor cell.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in), d (difference), bout (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, A - B, one bit per clock, LSB first.
// Ports: clk, reset (async active-high), bus (slave modport: start/A/B in;
//   busy/diff_bit/bit_valid/diff/borrow/done/ovf out).
// Optional: define SIGNED_OVF_EN to compute signed overflow on ovf; else ovf is tied 0.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input logic clk,
  input logic reset,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow_ff;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             done_q;
  logic             bit_q;
  logic             valid_q;

  logic             d;
  logic             bo;
  logic             last;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_ff),
    .d    (d),
    .bout (bo)
  );

  assign last = (cnt == CW'(WIDTH - 1));

`ifdef SIGNED_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      diff_sr   <= '0;
      borrow_ff <= 1'b0;
      cnt       <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      done_q    <= 1'b0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_sr      <= bus.A;
            b_sr      <= bus.B;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            state     <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          diff_sr   <= {d, diff_sr[WIDTH-1:1]};
          a_sr      <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr      <= {1'b0, b_sr[WIDTH-1:1]};
          borrow_ff <= bo;
          cnt       <= cnt + CW'(1);
          bit_q     <= d;
          valid_q   <= 1'b1;
          if (last) begin
            // Result registers load on the final edge so they are
            // valid in the same cycle done is high.
            state    <= S_DONE;
            diff_q   <= {d, diff_sr[WIDTH-1:1]};
            borrow_q <= bo;
            done_q   <= 1'b1;
`ifdef SIGNED_OVF_EN
            // a_sr[0]/b_sr[0] hold the operand MSBs at this edge.
            ovf_q <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == S_SHIFT);
  assign bus.diff_bit  = bit_q;
  assign bus.bit_valid = valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.done      = done_q;
endmodule
